// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for an RV32I MEM stage. It accepts one load or store
// at a time, waits a fixed number of cycles, performs the access on an
// internal word array and then holds the response until the CPU takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the backing array
//   LATENCY      cycles from request acceptance to array access (1..15)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   req_valid    request presented by the CPU
//   req_ready    high only while idle; a request is taken when both are high
//   req_write    1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    store data, lane-0 aligned
//   req_funct3   RV32I load/store width code
//   resp_valid   response available (held until resp_ready)
//   resp_ready   CPU accepts the response
//   resp_rdata   extended load data; 0 for stores and errors
//   resp_err     misaligned, out-of-range or illegal-funct3 request
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Select the addressed byte/half lane of a word and sign/zero extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_v;
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  result_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  result_v = {{16{half_v[15]}}, half_v};
      3'b010:  result_v = word;
      3'b100:  result_v = {24'h00_0000, byte_v};
      3'b101:  result_v = {16'h0000, half_v};
      default: result_v = 32'h0000_0000;
    endcase
    return result_v;
  endfunction

  // Merge store data into the addressed lane(s), leaving the other lanes as-is.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] merged_v;
    merged_v = word;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    merged_v[7:0]   = wdata[7:0];
          2'd1:    merged_v[15:8]  = wdata[7:0];
          2'd2:    merged_v[23:16] = wdata[7:0];
          default: merged_v[31:24] = wdata[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) begin
          merged_v[31:16] = wdata[15:0];
        end else begin
          merged_v[15:0]  = wdata[15:0];
        end
      end
      3'b010:  merged_v = wdata;
      default: merged_v = word;
    endcase
    return merged_v;
  endfunction

  // Legal width codes differ between loads and stores.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    logic legal_v;
    if (write) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal_v = 1'b1;
        default:                legal_v = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_v = 1'b1;
        default:                                legal_v = 1'b0;
      endcase
    end
    return legal_v;
  endfunction

  // Halfword codes need an even address, the word code a 4-byte aligned one.
  function automatic logic misaligned(input logic [1:0] lane, input logic [2:0] f3);
    logic mis_v;
    case (f3)
      3'b001, 3'b101: mis_v = lane[0];
      3'b010:         mis_v = (lane != 2'b00);
      default:        mis_v = 1'b0;
    endcase
    return mis_v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    cnt_r;
  logic          write_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [2:0]    funct3_r;
  logic [31:0]   rdata_r;
  logic          err_r;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_s;
  logic          access_s;
  logic          handshake_s;
  logic          in_range_s;
  logic          err_s;
  logic          we_s;
  logic [AW-1:0] word_idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   load_data_s;
  logic [31:0]   wr_word_s;

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;

  assign accept_s    = (state_r == IDLE) && req_valid;
  assign access_s    = (state_r == WAIT) && (cnt_r == 4'd0);
  assign handshake_s = (state_r == RESP) && resp_ready;

  // Decode the captured request: range, alignment, width legality, lane data.
  always_comb begin
    in_range_s  = ({2'b00, addr_r[31:2]} < DEPTH_LIMIT);
    word_idx_s  = addr_r[AW+1:2];
    err_s       = !in_range_s
                  || misaligned(addr_r[1:0], funct3_r)
                  || !funct3_legal(write_r, funct3_r);
    if (in_range_s) begin
      rd_word_s = mem[word_idx_s];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
    load_data_s = extend_load(rd_word_s, addr_r[1:0], funct3_r);
    wr_word_s   = merge_store(rd_word_s, wdata_r, addr_r[1:0], funct3_r);
    // Reset has priority: an access edge that coincides with reset must not write.
    we_s        = rst && access_s && write_r && !err_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r    <= 4'd0;
      write_r  <= 1'b0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      funct3_r <= 3'b000;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        write_r  <= req_write;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
        funct3_r <= req_funct3;
        cnt_r    <= CNT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      if (access_s) begin
        err_r <= err_s;
        // Stores and faulting requests return zero data.
        if (err_s || write_r) begin
          rdata_r <= 32'h0000_0000;
        end else begin
          rdata_r <= load_data_s;
        end
      end else if (handshake_s) begin
        err_r   <= 1'b0;
        rdata_r <= 32'h0000_0000;
      end else begin
        err_r   <= err_r;
        rdata_r <= rdata_r;
      end
    end
  end

  // Backing array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[word_idx_s] <= wr_word_s;
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; rst=0 at a rising edge resets the block.
REQ-005 req_valid  input  1  CPU MEM stage presents a request.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2 value), lane-0 aligned.
REQ-010 req_funct3  input  3  RV32I load/store width code.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned, out-of-range or illegal-funct3 request.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 Request accepted at a rising edge where req_valid=1 and req_ready=1; req_write, req_addr, req_wdata, req_funct3 are captured then and later input changes are ignored.
REQ-017 Acceptance: IDLE->WAIT, latency counter loaded with LATENCY-1.
REQ-018 In WAIT: counter decrements each edge; at the edge where counter=0, access is performed and FSM moves to RESP; resp_valid is therefore visible from LATENCY edges after acceptance.
REQ-019 RESP: resp_valid, resp_rdata, resp_err held stable until an edge with resp_ready=1, then RESP->IDLE; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-020 Word index = addr[31:2]; index >= DEPTH_WORDS -> error.
REQ-021 Alignment: half (funct3 001/101) needs addr[0]=0; word (010) needs addr[1:0]=00; violation -> error.
REQ-022 Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; legal store funct3: 000 sb, 001 sh, 010 sw; any other -> error.
REQ-023 Loads: lb/lh sign-extend, lbu/lhu zero-extend selected byte/half lane (byte lane addr[1:0], half lane addr[1]); lw returns full word.
REQ-024 Stores: sb writes req_wdata[7:0] into byte lane addr[1:0]; sh writes req_wdata[15:0] into half lane addr[1]; sw writes full word; other lanes unchanged.
REQ-025 Error: no array write, resp_rdata=0, resp_err=1; error responses obey same latency and handshake.
REQ-026 Successful store: resp_rdata=0, resp_err=0.
REQ-027 Load immediately after store to same address returns the stored data.
REQ-028 req_valid while not IDLE is ignored; no queuing.

Reset
REQ-029 rst=0 at an edge: FSM -> IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from first edge with rst=1.
REQ-030 Reset has priority over every other event, including simultaneous acceptance or handshake.
REQ-031 Reset in WAIT abandons the transaction with no array write; reset in RESP drops the pending response.
REQ-032 Array contents are not cleared by reset.

Verification
REQ-033 LATENCY=2: sw addr 0x10 data 0xDEADBEEF accepted at edge k -> resp_valid=1 after edge k+2, err=0; then lw 0x10 -> rdata 0xDEADBEEF.
REQ-034 After REQ-033: sb 0x11 data 0x80; lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0xDEAD80EF.
REQ-035 lh 0x13 and sw 0x12 -> resp_err=1, rdata=0; subsequent lw 0x10 unchanged.
REQ-036 lw 4*DEPTH_WORDS and load funct3 011 -> resp_err=1; resp_ready held 0 for 5 cycles -> resp_valid and data stable throughout.
REQ-037 sw 0x20 data 0x12345678 accepted, rst=0 one cycle later (WAIT) -> req_ready=1 after release; lw 0x20 returns prior contents, not 0x12345678.
REQ-038 req_valid held high across response with resp_ready=1 -> next acceptance exactly LATENCY+2 edges after previous.
